rr_encoder: RTL



---
 rtl/enc_pkg.sv | 17 +
 rtl/rr_pick.sv | 34 +++
 rtl/rr_encoder.sv | 81 ++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: constants and helpers shared by the encoder and decoder-side users.
//   N     : number of request lines (power of two)
//   W     : index width, log2(N)
//   idx_t : binary index type
//   onehot: index -> one-hot vector (the decoder function)
package enc_pkg;

  localparam int N = 16;
  localparam int W = $clog2(N);

  typedef logic [W-1:0] idx_t;

  function automatic logic [N-1:0] onehot(input idx_t i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick.
//   vec : candidate bits
//   ptr : search start position
//   sel : first set bit of vec at or above ptr, wrapping to bit 0
//   any : vec has at least one bit set
module rr_pick
  import enc_pkg::*;
#(
  parameter int N = enc_pkg::N,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         any
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;

  // Two-pass search: the lowest bit at or above ptr wins; if there is none,
  // the lowest bit overall is the wrapped-around winner.
  always_comb begin
    hi_mask = {N{1'b1}} << ptr;
    masked  = vec & hi_mask;
    any     = |vec;
    sel     = '0;
    for (int i = N-1; i >= 0; i--)
      if (vec[i]) sel = W'(i);
    for (int i = N-1; i >= 0; i--)
      if (masked[i]) sel = W'(i);
  end

endmodule

// File: rtl/rr_encoder.sv
// rr_encoder: round-robin N-to-log2(N) request encoder.
// Request strobes accumulate into a pending set; one index per served
// request is emitted on a valid/ready output, in rotating priority order.
//   clk, rst_n : clock, async active-low reset
//   req        : request strobes, any number high per cycle
//   out_idx    : served index (meaningful while out_valid)
//   out_valid  : out_idx holds a served request
//   out_ready  : consumer accepts on out_valid && out_ready
//   drop       : one-cycle pulse, a request merged into a pending bit
//   idle       : nothing pending and nothing on the output
module rr_encoder
  import enc_pkg::*;
#(
  parameter int N = enc_pkg::N,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         drop,
  output logic         idle
);

  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] ptr_q;
  logic [W-1:0] out_idx_q;
  logic         out_valid_q;
  logic         drop_q, drop_d;

  logic [W-1:0] sel;
  logic         any;
  logic         load;
  logic [N-1:0] clr;

  // Search runs on registered pending only: same-cycle req is never eligible.
  rr_pick #(.N(N), .W(W)) u_pick (
    .vec (pending_q),
    .ptr (ptr_q),
    .sel (sel),
    .any (any)
  );

  // Load when the output slot is empty or being drained this edge, so a
  // ready consumer sees one index per cycle with no bubble.
  assign load = (!out_valid_q || out_ready) && any;
  assign clr  = load ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;

  // Set wins over clear: a req on the bit being served re-arms it.
  assign pending_d = (pending_q & ~clr) | req;
  // Only a merge into a bit that stays pending loses an event.
  assign drop_d    = |(req & pending_q & ~clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      ptr_q       <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
      if (load) begin
        out_idx_q   <= sel;
        out_valid_q <= 1'b1;
        ptr_q       <= sel + W'(1);  // wraps naturally, N is a power of two
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;          // out_idx holds its last value
      end
    end
  end

  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign drop      = drop_q;
  assign idle      = ~|pending_q & ~out_valid_q;

endmodule
